// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: sequencer for the QARMA-128 S-box layer over a 128-bit state.
// The forward or inverse byte S-box is applied to all 16 bytes. A shared bank of
// LANES byte transforms handles one group of LANES bytes per cycle, in place.
//
// Parameters:
//   LANES        bytes per cycle; legal values 1, 2, 4, 8, 16
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  request valid (din, inv)
//   start_ready  request can be accepted (IDLE only)
//   inv          0 = forward S-box, 1 = inverse S-box; sampled at accept
//   din          input state, byte k = din[8k+7:8k]
//   dout_valid   dout holds a finished result (DONE)
//   dout_ready   consumer accepts dout
//   dout         transformed state
//   busy         high while groups are being transformed
//   ops_done     saturating count of completed results (only with SBOX_SEQ_PERF_EN)
//
// Build option: define SBOX_SEQ_PERF_EN to add the ops_done counter and port.
module sbox_layer_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic         inv,
  input  logic [127:0] din,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout,
  output logic         busy
`ifdef SBOX_SEQ_PERF_EN
  ,
  output logic [15:0]  ops_done
`endif
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sbox_layer_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned Steps   = 16 / LANES;
  localparam int unsigned GroupW  = 8 * LANES;
  localparam logic [3:0]  LastCnt = 4'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} st_e;

  st_e          st_q, st_d;
  logic [127:0] sreg_q, sreg_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         inv_q, inv_d;

  logic [GroupW-1:0] grp_in, grp_out;

  function automatic logic [3:0] sigma(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'h0;
      4'h1: r = 4'he;
      4'h2: r = 4'h2;
      4'h3: r = 4'ha;
      4'h4: r = 4'h9;
      4'h5: r = 4'hf;
      4'h6: r = 4'h8;
      4'h7: r = 4'hb;
      4'h8: r = 4'h6;
      4'h9: r = 4'h4;
      4'ha: r = 4'h3;
      4'hb: r = 4'h7;
      4'hc: r = 4'hd;
      4'hd: r = 4'hc;
      4'he: r = 4'h1;
      default: r = 4'h5;
    endcase
    return r;
  endfunction

  // Forward: low nibble feeds the even output bits, high nibble the odd ones.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [3:0] lo, hi;
    lo = sigma(b[3:0]);
    hi = sigma(b[7:4]);
    return {hi[3], lo[3], hi[2], lo[2], hi[1], lo[1], hi[0], lo[0]};
  endfunction

  // Inverse: gather even/odd input bits into nibbles, then substitute.
  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [3:0] ev, od;
    ev = {b[6], b[4], b[2], b[0]};
    od = {b[7], b[5], b[3], b[1]};
    return {sigma(od), sigma(ev)};
  endfunction

  // Group select mux and the shared lane bank.
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < int'(Steps); g++) begin
      if (cnt_q == 4'(g)) grp_in = sreg_q[g*GroupW +: GroupW];
    end
    grp_out = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      grp_out[8*l +: 8] = inv_q ? sbox_inv(grp_in[8*l +: 8]) : sbox_fwd(grp_in[8*l +: 8]);
    end
  end

  always_comb begin
    st_d        = st_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    start_ready = 1'b0;
    busy        = 1'b0;
    dout_valid  = 1'b0;
    unique case (st_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) begin
          sreg_d = din;
          inv_d  = inv;
          cnt_d  = '0;
          st_d   = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        // Only the active group is rewritten; other bytes hold their value.
        for (int g = 0; g < int'(Steps); g++) begin
          if (cnt_q == 4'(g)) sreg_d[g*GroupW +: GroupW] = grp_out;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastCnt) st_d = StDone;
      end
      StDone: begin
        dout_valid = 1'b1;
        if (dout_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      sreg_q <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
    end
  end

  assign dout = sreg_q;

`ifdef SBOX_SEQ_PERF_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= '0;
    end else if (dout_valid && dout_ready && (ops_q != 16'hFFFF)) begin
      ops_q <= ops_q + 16'd1;
    end
  end

  assign ops_done = ops_q;
`endif

endmodule

// File: tb/tb_sbox_layer_seq.sv
module tb_sbox_layer_seq;

  localparam int unsigned LANES = 4;
  localparam int Steps = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         inv = 1'b0;
  logic [127:0] din = '0;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [127:0] dout;
  logic         busy;
`ifdef SBOX_SEQ_PERF_EN
  logic [15:0]  ops_done;
`endif

  int compared = 0;
  int mismatched = 0;
  int ops_expected = 0;

  always #5 clk = ~clk;

  sbox_layer_seq #(.LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .inv        (inv),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .busy       (busy)
`ifdef SBOX_SEQ_PERF_EN
    ,
    .ops_done   (ops_done)
`endif
  );

  // Reference model: direct bit-level reading of the byte transform rules.
  function automatic logic [3:0] sig(input logic [3:0] x);
    logic [3:0] t [16] = '{4'h0, 4'he, 4'h2, 4'ha, 4'h9, 4'hf, 4'h8, 4'hb,
                           4'h6, 4'h4, 4'h3, 4'h7, 4'hd, 4'hc, 4'h1, 4'h5};
    return t[x];
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] b, input logic iv);
    logic [7:0] o;
    logic [3:0] a, c;
    o = '0;
    if (!iv) begin
      a = sig(b[3:0]);
      c = sig(b[7:4]);
      for (int i = 0; i < 4; i++) begin
        o[2*i]   = a[i];
        o[2*i+1] = c[i];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        a[i] = b[2*i];
        c[i] = b[2*i+1];
      end
      o[3:0] = sig(a);
      o[7:4] = sig(c);
    end
    return o;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] x, input logic iv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = model_byte(x[8*k +: 8], iv);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full operation with latency, stability and handshake checks.
  task automatic run_op(input logic [127:0] d, input logic iv, input int hold, input bit poke,
                        input string tag, output logic [127:0] res);
    logic [127:0] expv;
    int n;
    expv = model_state(d, iv);
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (start_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s idle_wait: start_ready=%b want 1", tag, start_ready);
    end
    din = d;
    inv = iv;
    start_valid = 1'b1;
    dout_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = poke;
    din = ~d;
    inv = ~iv;
    for (int k = 0; k < Steps; k++) begin
      compared++;
      if ({busy, dout_valid, start_ready} !== 3'b100) begin
        mismatched++;
        $display("FAIL %s busy_phase[%0d]: busy/valid/ready=%b want 100", tag, k,
                 {busy, dout_valid, start_ready});
      end
      @(negedge clk);
    end
    compared++;
    if ({busy, dout_valid, start_ready} !== 3'b010) begin
      mismatched++;
      $display("FAIL %s done_phase: busy/valid/ready=%b want 010", tag,
               {busy, dout_valid, start_ready});
    end
    compared++;
    if (dout !== expv) begin
      mismatched++;
      $display("FAIL %s result: dout=%h want %h", tag, dout, expv);
    end
    res = dout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      compared++;
      if (dout_valid !== 1'b1 || dout !== expv) begin
        mismatched++;
        $display("FAIL %s hold[%0d]: valid=%b dout=%h want 1 %h", tag, h, dout_valid, dout, expv);
      end
    end
    start_valid = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    ops_expected++;
    compared++;
    if ({busy, dout_valid, start_ready} !== 3'b001) begin
      mismatched++;
      $display("FAIL %s after_handshake: busy/valid/ready=%b want 001", tag,
               {busy, dout_valid, start_ready});
    end
    if (poke) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || dout_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL %s poke_ignored: busy=%b valid=%b want 0 0", tag, busy, dout_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 128'h0) begin
      mismatched++;
      $display("FAIL reset_values: valid=%b busy=%b dout=%h want 0 0 0", dout_valid, busy, dout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (start_ready !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: ready=%b valid=%b busy=%b want 1 0 0",
               start_ready, dout_valid, busy);
    end
  endtask

  task automatic test_known();
    logic [127:0] r;
    run_op(128'h0, 1'b0, 0, 1'b0, "zero_fwd", r);
    compared++;
    if (r !== 128'h0) begin
      mismatched++;
      $display("FAIL zero_fwd_const: dout=%h want 0", r);
    end
    run_op({16{8'h01}}, 1'b0, 0, 1'b0, "fwd01", r);
    compared++;
    if (r !== {16{8'h54}}) begin
      mismatched++;
      $display("FAIL fwd01_const: dout=%h want %h", r, {16{8'h54}});
    end
    run_op({16{8'hFF}}, 1'b0, 1, 1'b0, "fwdFF", r);
    compared++;
    if (r !== {16{8'h33}}) begin
      mismatched++;
      $display("FAIL fwdFF_const: dout=%h want %h", r, {16{8'h33}});
    end
    run_op({16{8'h54}}, 1'b1, 0, 1'b0, "inv54", r);
    compared++;
    if (r !== {16{8'h01}}) begin
      mismatched++;
      $display("FAIL inv54_const: dout=%h want %h", r, {16{8'h01}});
    end
  endtask

  task automatic test_random_roundtrip();
    logic [127:0] x, y, z;
    for (int i = 0; i < 6; i++) begin
      x = rand128();
      run_op(x, 1'b0, int'($urandom_range(0, 3)), 1'b0, "rand_fwd", y);
      run_op(y, 1'b1, int'($urandom_range(0, 3)), 1'b0, "rand_inv", z);
      compared++;
      if (z !== x) begin
        mismatched++;
        $display("FAIL roundtrip[%0d]: got=%h want %h", i, z, x);
      end
    end
    x = rand128();
    run_op(x, 1'b1, 0, 1'b0, "rand_inv_only", y);
  endtask

  task automatic test_hold_and_poke();
    logic [127:0] r;
    run_op(rand128(), 1'b0, 10, 1'b1, "hold10_poke", r);
    run_op(rand128(), 1'b1, 3, 1'b1, "hold3_poke_inv", r);
  endtask

  task automatic test_back_to_back();
    logic [127:0] d, expv;
    int hits[$];
    d = rand128();
    expv = model_state(d, 1'b0);
    @(negedge clk);
    din = d;
    inv = 1'b0;
    start_valid = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 3 * (Steps + 2); c++) begin
      @(negedge clk);
      if (dout_valid) begin
        hits.push_back(c);
        compared++;
        if (dout !== expv) begin
          mismatched++;
          $display("FAIL b2b_result@%0d: dout=%h want %h", c, dout, expv);
        end
      end
    end
    start_valid = 1'b0;
    dout_ready = 1'b0;
    ops_expected += hits.size();
    compared++;
    if (hits.size() != 3) begin
      mismatched++;
      $display("FAIL b2b_count: results=%0d want 3", hits.size());
    end else begin
      compared++;
      if (hits[0] != Steps) begin
        mismatched++;
        $display("FAIL b2b_latency: first at %0d want %0d", hits[0], Steps);
      end
      for (int i = 1; i < 3; i++) begin
        compared++;
        if (hits[i] - hits[i-1] != Steps + 2) begin
          mismatched++;
          $display("FAIL b2b_period[%0d]: gap=%0d want %0d", i, hits[i] - hits[i-1], Steps + 2);
        end
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    din = rand128() | 128'h1;
    inv = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 128'h0 || start_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_immediate: valid=%b busy=%b ready=%b dout=%h want 0 0 1 0",
               dout_valid, busy, start_ready, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ops_expected = 0;
    for (int c = 0; c < Steps + 3; c++) begin
      @(negedge clk);
      compared++;
      if (dout_valid !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_discard[%0d]: valid=%b busy=%b want 0 0", c, dout_valid, busy);
      end
    end
  endtask

  task automatic test_perf();
    logic [127:0] r;
    for (int i = 0; i < 3; i++) run_op(rand128(), i[0], 0, 1'b0, "perf_op", r);
`ifdef SBOX_SEQ_PERF_EN
    compared++;
    if (ops_done !== 16'(ops_expected)) begin
      mismatched++;
      $display("FAIL ops_done: got=%0d want %0d", ops_done, ops_expected);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known();
    test_random_roundtrip();
    test_hold_and_poke();
    test_back_to_back();
    test_abort();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
